fp_div_pack: RTL

//  Result-assembly end of the SRT floating-point divider. It takes the sign, the pre-computed biased

---
 rtl/fp_div_pack.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fp_div_pack.sv
// Result assembly for the SRT divider: normalize, round-to-nearest-even, pack IEEE-754 single.
// Latency: 2 cycles from input accept to out_valid, one result per cycle sustained.
// Backpressure: out_ready low stalls stage 2, then stage 1. in_ready is combinational from out_ready.
module fp_div_pack #(
    parameter int FP_WIDTH   = 32,
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23,
    parameter int BIAS       = 127,
    parameter int QW         = MANT_WIDTH + 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [EXP_WIDTH+1:0]   in_exp,
    input  logic [QW-1:0]          in_quot,
    input  logic                   in_sticky,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FP_WIDTH-1:0]    out_result,
    output logic [2:0]             out_flags
);

    // Exponent is carried two bits wider than the field: one bit of headroom
    // above the all-ones code and a sign bit for underflow detection.
    localparam int EW = EXP_WIDTH + 2;
    localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_WIDTH) - 1);
    // Bits of the normalized fraction below the guard bit.
    localparam int LOW_W = QW - 2 - MANT_WIDTH;

    // BIAS only matters upstream (the exponent arrives already biased).
    localparam int UNUSED_BIAS = BIAS;

    // ---------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------
    logic r_s1_valid;
    logic r_s2_valid;
    logic w_s2_en;
    logic w_s1_en;

    assign w_s2_en   = !r_s2_valid || out_ready;
    assign w_s1_en   = !r_s1_valid || w_s2_en;
    assign in_ready  = w_s1_en;
    assign out_valid = r_s2_valid;

    // ---------------------------------------------------------------
    // Stage 1: normalize
    // ---------------------------------------------------------------
    logic                  w_in_zero;
    logic [QW-2:0]         w_norm_frac;
    logic [EW-1:0]         w_norm_exp;

    logic                  r_s1_sign;
    logic                  r_s1_zero;
    logic                  r_s1_sticky;
    logic [EW-1:0]         r_s1_exp;
    logic [QW-2:0]         r_s1_frac;

    // Quotient lies in [0.5,2): at most one left shift puts the leading one in the integer bit.
    always_comb begin
        w_in_zero = (in_quot == '0);
        if (in_quot[QW-1]) begin
            w_norm_frac = in_quot[QW-2:0];
            w_norm_exp  = in_exp;
        end else begin
            w_norm_frac = {in_quot[QW-3:0], 1'b0};
            w_norm_exp  = in_exp - EW'(1);
        end
    end

    // Stage 1 register: loads whenever it is empty or its content moves on to stage 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_sign   <= 1'b0;
            r_s1_zero   <= 1'b0;
            r_s1_sticky <= 1'b0;
            r_s1_exp    <= '0;
            r_s1_frac   <= '0;
        end else if (w_s1_en) begin
            r_s1_valid  <= in_valid;
            r_s1_sign   <= in_sign;
            r_s1_zero   <= w_in_zero;
            r_s1_sticky <= in_sticky;
            r_s1_exp    <= w_norm_exp;
            r_s1_frac   <= w_norm_frac;
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: round and pack
    // ---------------------------------------------------------------
    logic [MANT_WIDTH-1:0] w_mant;
    logic                  w_guard;
    logic                  w_rest;
    logic                  w_round_up;
    logic [MANT_WIDTH:0]   w_mant_sum;
    logic                  w_carry;
    logic [EW-1:0]         w_rnd_exp;
    logic                  w_inexact;
    logic                  w_exp_ovf;
    logic                  w_exp_unf;
    logic [FP_WIDTH-1:0]   w_result;
    logic [2:0]            w_flags;

    // Round-to-nearest-even; a carry out of the fraction bumps the exponent and leaves fraction zero.
    always_comb begin
        w_mant     = r_s1_frac[QW-2 -: MANT_WIDTH];
        w_guard    = r_s1_frac[LOW_W];
        w_rest     = (|r_s1_frac[LOW_W-1:0]) | r_s1_sticky;
        w_round_up = w_guard & (w_rest | w_mant[0]);
        w_mant_sum = {1'b0, w_mant} + (MANT_WIDTH+1)'(w_round_up);
        w_carry    = w_mant_sum[MANT_WIDTH];
        w_rnd_exp  = r_s1_exp + EW'(w_carry);
        w_inexact  = w_guard | w_rest;
        // Exponent is two's complement: sign bit set means negative.
        w_exp_ovf  = !w_rnd_exp[EW-1] && (w_rnd_exp >= EXP_MAX);
        w_exp_unf  = w_rnd_exp[EW-1] || (w_rnd_exp == '0);
    end

    // Final packing with zero, overflow-to-infinity and flush-to-zero cases.
    always_comb begin
        w_result = {r_s1_sign, w_rnd_exp[EXP_WIDTH-1:0], w_mant_sum[MANT_WIDTH-1:0]};
        w_flags  = {2'b00, w_inexact};
        if (r_s1_zero) begin
            w_result = {r_s1_sign, {(FP_WIDTH-1){1'b0}}};
            w_flags  = 3'b000;
        end else if (w_exp_ovf) begin
            w_result = {r_s1_sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
            w_flags  = 3'b101;
        end else if (w_exp_unf) begin
            w_result = {r_s1_sign, {(FP_WIDTH-1){1'b0}}};
            w_flags  = 3'b011;
        end
    end

    // Output register: frozen while a valid result waits for the consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (w_s2_en) begin
            r_s2_valid <= r_s1_valid;
            out_result <= w_result;
            out_flags  <= w_flags;
        end
    end

endmodule
